// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: loads the fabric configuration shift chain from a word-wide bitstream.
// Words arrive over valid/ready and are shifted LSB-first on prog_in/prog_en for exactly CHAIN_LEN bits.
// Optional readback-verify pass: define CFG_CHAIN_LOADER_READBACK_EN.
module cfg_chain_loader #(
    parameter int unsigned CHAIN_LEN = 4480,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              prog_in,
    output logic              prog_en,
    input  logic              prog_out,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned BIT_CW    = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WORD_CW   = $clog2(NUM_WORDS + 1);
    localparam int unsigned SH_CW     = $clog2(WORD_W + 1);

`ifdef CFG_CHAIN_LOADER_READBACK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, VERIFY = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
    logic unused_prog_out;
    assign unused_prog_out = prog_out;
`endif

    state_t              state_q, state_d;
    logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_CW-1:0]  word_cnt_q, word_cnt_d;
    logic                hold_vld_q, hold_vld_d;
    logic [WORD_W-1:0]   hold_data_q, hold_data_d;
    logic                sh_vld_q, sh_vld_d;
    logic [WORD_W-1:0]   sh_data_q, sh_data_d;
    logic [SH_CW-1:0]    sh_cnt_q, sh_cnt_d;
    logic                prog_in_d, prog_en_d, word_ready_d, busy_d, done_d, error_d;

    // Next-state, buffer movement and next output values.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        hold_vld_d   = hold_vld_q;
        hold_data_d  = hold_data_q;
        sh_vld_d     = sh_vld_q;
        sh_data_d    = sh_data_q;
        sh_cnt_d     = sh_cnt_q;
        prog_in_d    = prog_in;
        prog_en_d    = 1'b0;
        done_d       = done;
        error_d      = error;
        busy_d       = 1'b0;
        word_ready_d = 1'b0;

        if (state_q == IDLE || state_q == DONE) begin
            if (start) begin
                state_d    = LOAD;
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                hold_vld_d = 1'b0;
                sh_vld_d   = 1'b0;
                sh_cnt_d   = '0;
                done_d     = 1'b0;
                error_d    = 1'b0;
            end
        end else if (bit_cnt_q == BIT_CW'(CHAIN_LEN)) begin
            // Pass complete: drop leftover upper bits and rearm counters.
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            hold_vld_d = 1'b0;
            sh_vld_d   = 1'b0;
            sh_cnt_d   = '0;
`ifdef CFG_CHAIN_LOADER_READBACK_EN
            if (state_q == LOAD) begin
                state_d = VERIFY;
            end else begin
                state_d = DONE;
                done_d  = 1'b1;
            end
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
        end else begin
            if (sh_vld_q) begin
                prog_en_d = 1'b1;
                prog_in_d = sh_data_q[0];
                sh_data_d = sh_data_q >> 1;
                sh_cnt_d  = sh_cnt_q - SH_CW'(1);
                bit_cnt_d = bit_cnt_q + BIT_CW'(1);
                if (sh_cnt_q == SH_CW'(1)) begin
                    sh_vld_d = 1'b0;
                end
            end
            // Reload on the edge the last bit leaves, so streaming is gapless.
            if ((!sh_vld_q || sh_cnt_q == SH_CW'(1)) && hold_vld_q) begin
                sh_data_d  = hold_data_q;
                sh_cnt_d   = SH_CW'(WORD_W);
                sh_vld_d   = 1'b1;
                hold_vld_d = 1'b0;
            end
            if (word_valid && word_ready) begin
                hold_vld_d  = 1'b1;
                hold_data_d = word_data;
                word_cnt_d  = word_cnt_q + WORD_CW'(1);
            end
        end

`ifdef CFG_CHAIN_LOADER_READBACK_EN
        // Chain tail must equal the bit currently being shifted in.
        if (state_q == VERIFY && prog_en && (prog_out != prog_in)) begin
            error_d = 1'b1;
        end
`endif

        busy_d       = (state_d != IDLE) && (state_d != DONE);
        word_ready_d = busy_d && !hold_vld_d && (word_cnt_d < WORD_CW'(NUM_WORDS));
    end

    // State, buffers and registered outputs.
    always_ff @(posedge prog_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            sh_vld_q    <= 1'b0;
            sh_data_q   <= '0;
            sh_cnt_q    <= '0;
            prog_in     <= 1'b0;
            prog_en     <= 1'b0;
            word_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            sh_vld_q    <= sh_vld_d;
            sh_data_q   <= sh_data_d;
            sh_cnt_q    <= sh_cnt_d;
            prog_in     <= prog_in_d;
            prog_en     <= prog_en_d;
            word_ready  <= word_ready_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
        end
    end

endmodule
